// File: rtl/udma_cfg_demux_pkg.sv
// Shared types and constants for the uDMA cfg-bus demultiplexer.
package udma_cfg_demux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_DECODE  = 2'b01,
      ERR_TIMEOUT = 2'b10
   } err_code_e;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/udma_cfg_timeout_cnt.sv
// Unready-cycle counter for the cfg demux; expired is high once TIMEOUT
// unready cycles have been counted. clr has priority over en.
module udma_cfg_timeout_cnt #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   // Count unready cycles of the pending request, restart when it ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/udma_cfg_demux.sv
// uDMA cfg-bus demultiplexer: routes one upstream cfg port to NB_TGT register
// banks by the upper address bits, completes requests to missing banks with
// an error response. Optional macro UDMA_CFG_DEMUX_TIMEOUT_EN adds a forced
// completion for targets that stay unready for TIMEOUT cycles.
module udma_cfg_demux
   import udma_cfg_demux_pkg::*;
#(
   parameter  int NB_TGT  = 2,
   parameter  int ADDR_W  = 6,
   parameter  int TIMEOUT = 64,
   localparam int SEL_W   = (NB_TGT > 1) ? $clog2(NB_TGT) : 1
) (
   input  logic                     periph_clk_i,
   input  logic                     rstn_i,
   input  logic [31:0]              cfg_data_i,
   input  logic [ADDR_W-1:0]        cfg_addr_i,
   input  logic                     cfg_valid_i,
   input  logic                     cfg_rwn_i,
   output logic                     cfg_ready_o,
   output logic [31:0]              cfg_data_o,
   output logic [NB_TGT-1:0]        tgt_valid_o,
   output logic [ADDR_W-SEL_W-1:0]  tgt_addr_o,
   output logic [31:0]              tgt_data_o,
   output logic                     tgt_rwn_o,
   input  logic [NB_TGT-1:0]        tgt_ready_i,
   input  logic [NB_TGT-1:0][31:0]  tgt_data_i,
   output logic                     err_o,
   output logic [1:0]               err_code_o
);

   if (NB_TGT < 1 || NB_TGT > 16 || ADDR_W <= SEL_W || TIMEOUT < 2) begin : g_bad_params
      $error("udma_cfg_demux: illegal parameter set");
   end

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx;
   logic [SEL_W-1:0] sel_q;
   logic             err_q;
   logic             legal;
   logic             sel_ready;
   logic             timed_out;
   logic             forced;
   logic             hs;
   logic             err_flag;

   assign idx        = cfg_addr_i[ADDR_W-1 -: SEL_W];
   assign tgt_addr_o = cfg_addr_i[ADDR_W-SEL_W-1:0];
   assign tgt_data_o = cfg_data_i;
   assign tgt_rwn_o  = cfg_rwn_i;

   // Decode the bank index: is it an existing target, and is that target ready.
   always_comb begin
      legal     = 1'b0;
      sel_ready = 1'b0;
      for (int i = 0; i < NB_TGT; i++) begin
         if (idx == SEL_W'(i)) begin
            legal     = 1'b1;
            sel_ready = tgt_ready_i[i];
         end
      end
   end

`ifdef UDMA_CFG_DEMUX_TIMEOUT_EN
   logic cnt_expired;

   udma_cfg_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (periph_clk_i),
      .rst_n   (rstn_i),
      .clr     (~cfg_valid_i | cfg_ready_o),
      .en      (cfg_valid_i & ~cfg_ready_o),
      .expired (cnt_expired)
   );

   assign timed_out = cnt_expired & (state_q == BUSY);
`else
   assign timed_out = 1'b0;
`endif

   // Next state and request-path outputs; masked while reset is asserted.
   always_comb begin
      state_d     = state_q;
      tgt_valid_o = '0;
      cfg_ready_o = 1'b0;
      forced      = 1'b0;
      if (rstn_i && cfg_valid_i) begin
         if (!legal) begin
            cfg_ready_o = 1'b1;
         end else if (sel_ready) begin
            cfg_ready_o = 1'b1;
         end else if (timed_out) begin
            cfg_ready_o = 1'b1;
            forced      = 1'b1;
         end
         if (legal && !forced) begin
            for (int i = 0; i < NB_TGT; i++) begin
               tgt_valid_o[i] = (idx == SEL_W'(i));
            end
         end
      end
      case (state_q)
         IDLE: if (cfg_valid_i && !cfg_ready_o) state_d = BUSY;
         BUSY: if (!cfg_valid_i || cfg_ready_o) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge periph_clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   assign hs       = cfg_valid_i & cfg_ready_o;
   assign err_flag = ~legal | forced;

   // Capture the response source at each handshake and report errors a cycle later.
   always_ff @(posedge periph_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sel_q      <= '0;
         err_q      <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
      end else begin
         err_o <= hs & err_flag;
         if (hs) begin
            sel_q <= idx;
            err_q <= err_flag;
            if (!legal)      err_code_o <= ERR_DECODE;
            else if (forced) err_code_o <= ERR_TIMEOUT;
         end
      end
   end

   // Read data of the previous handshake: error pattern or the selected target.
   always_comb begin
      cfg_data_o = '0;
      for (int i = 0; i < NB_TGT; i++) begin
         if (sel_q == SEL_W'(i)) cfg_data_o = tgt_data_i[i];
      end
      if (err_q) cfg_data_o = ERR_RDATA;
   end

endmodule

// File: tb/tb_udma_cfg_demux.sv
// Self-checking bench for udma_cfg_demux (NB_TGT=3, ADDR_W=6, TIMEOUT=8).
module tb_udma_cfg_demux;

   localparam int NB = 3;
   localparam int AW = 6;
   localparam int TO = 8;
`ifdef UDMA_CFG_DEMUX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rstn;
   logic [31:0]        cfg_wdata;
   logic [AW-1:0]      cfg_addr;
   logic               cfg_valid;
   logic               cfg_rwn;
   logic               cfg_ready;
   logic [31:0]        cfg_rdata;
   logic [NB-1:0]      tgt_valid;
   logic [AW-3:0]      tgt_addr;
   logic [31:0]        tgt_wdata;
   logic               tgt_rwn;
   logic [NB-1:0]      tready;
   logic [NB-1:0][31:0] tdata;
   logic               err;
   logic [1:0]         err_code;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [1:0]  exp_code = 2'b00;

   always #5 clk = ~clk;

   udma_cfg_demux #(
      .NB_TGT  (NB),
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .periph_clk_i (clk),
      .rstn_i       (rstn),
      .cfg_data_i   (cfg_wdata),
      .cfg_addr_i   (cfg_addr),
      .cfg_valid_i  (cfg_valid),
      .cfg_rwn_i    (cfg_rwn),
      .cfg_ready_o  (cfg_ready),
      .cfg_data_o   (cfg_rdata),
      .tgt_valid_o  (tgt_valid),
      .tgt_addr_o   (tgt_addr),
      .tgt_data_o   (tgt_wdata),
      .tgt_rwn_o    (tgt_rwn),
      .tgt_ready_i  (tready),
      .tgt_data_i   (tdata),
      .err_o        (err),
      .err_code_o   (err_code)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected outcome of a request from the bank map and the target's latency.
   function automatic void model(input int idx, input int delay,
                                 output int cyc, output bit is_err, output logic [1:0] code);
      if (idx >= NB) begin
         cyc = 0; is_err = 1'b1; code = 2'b01;
      end else if (TO_EN && delay > TO) begin
         cyc = TO; is_err = 1'b1; code = 2'b10;
      end else begin
         cyc = delay; is_err = 1'b0; code = 2'b00;
      end
   endfunction

   // One request: target idx becomes ready `delay` cycles after valid rises.
   task automatic run_req(input int idx, input int delay, input bit rwn);
      int          exp_cyc;
      bit          exp_err;
      logic [1:0]  code;
      int          c;
      bit          done;
      bit          forced_cyc;
      logic [31:0] wd;
      logic [3:0]  lo;
      logic [1:0]  ib;
      logic [NB-1:0] exp_v;
      model(idx, delay, exp_cyc, exp_err, code);
      wd = $urandom;
      lo = 4'($urandom);
      ib = 2'(idx);
      cfg_addr  = {ib, lo};
      cfg_wdata = wd;
      cfg_rwn   = rwn;
      cfg_valid = 1'b1;
      done = 1'b0;
      c = 0;
      while (!done) begin
         tready = (idx < NB && c >= delay) ? NB'(1 << idx) : '0;
         @(negedge clk);
         if (c == 0) begin
            chk("tgt_addr", 32'(tgt_addr), 32'(lo));
            chk("tgt_wdata", tgt_wdata, wd);
            chk("tgt_rwn", 32'(tgt_rwn), 32'(rwn));
         end
         forced_cyc = TO_EN && (c == TO) && (delay > TO) && (idx < NB);
         exp_v = (idx < NB && !forced_cyc) ? NB'(1 << idx) : '0;
         chk("tgt_valid", 32'(tgt_valid), 32'(exp_v));
         if (cfg_ready === 1'b1 || c >= 300) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            c++;
         end
      end
      chk("hs_cycle", c, exp_cyc);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      tready    = '0;
      @(negedge clk);
      chk("ready_drop", 32'(cfg_ready), 32'd0);
      if (exp_err) exp_code = code;
      if (rwn) chk("rdata", cfg_rdata, exp_err ? 32'hDEAD_BEEF : tdata[idx]);
      chk("err_pulse", 32'(err), 32'(exp_err));
      chk("err_code", 32'(err_code), 32'(exp_code));
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_clear", 32'(err), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn      = 1'b0;
      cfg_wdata = '0;
      cfg_addr  = '0;
      cfg_valid = 1'b0;
      cfg_rwn   = 1'b0;
      tready    = '0;
      tdata[0]  = 32'hA0A0_0000;
      tdata[1]  = 32'hA1A1_1111;
      tdata[2]  = 32'hA2A2_2222;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_tvalid", 32'(tgt_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      chk("rst_rdata", cfg_rdata, tdata[0]);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Immediate read from target 1
      tdata[1] = 32'h1234_5678;
      run_req(1, 0, 1'b1);

      // Back-to-back reads idx 0 then idx 2
      tdata[0]  = 32'h0000_C0DE;
      tdata[2]  = 32'h2222_BEAD;
      tready    = '1;
      cfg_valid = 1'b1;
      cfg_rwn   = 1'b1;
      cfg_addr  = {2'd0, 4'h5};
      @(negedge clk);
      chk("b2b_ready0", 32'(cfg_ready), 32'd1);
      chk("b2b_tvalid0", 32'(tgt_valid), 32'b001);
      @(posedge clk); #1;
      cfg_addr = {2'd2, 4'hA};
      @(negedge clk);
      chk("b2b_ready2", 32'(cfg_ready), 32'd1);
      chk("b2b_tvalid2", 32'(tgt_valid), 32'b100);
      chk("b2b_rdata0", cfg_rdata, 32'h0000_C0DE);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      tready    = '0;
      @(negedge clk);
      chk("b2b_rdata2", cfg_rdata, 32'h2222_BEAD);
      chk("b2b_err", 32'(err), 32'd0);
      @(posedge clk); #1;

      // Decode error
      run_req(3, 0, 1'b1);

`ifdef UDMA_CFG_DEMUX_TIMEOUT_EN
      run_req(1, 1000, 1'b1);
      run_req(2, TO, 1'b1);
`else
      run_req(2, 200, 1'b1);
`endif

      // Asynchronous reset while BUSY
      cfg_addr  = {2'd1, 4'h3};
      cfg_valid = 1'b1;
      cfg_rwn   = 1'b1;
      tready    = '0;
      repeat (3) @(posedge clk);
      #1;
      tready = '1;
      rstn   = 1'b0;
      #1;
      exp_code = 2'b00;
      chk("arst_ready", 32'(cfg_ready), 32'd0);
      chk("arst_tvalid", 32'(tgt_valid), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      chk("arst_code", 32'(err_code), 32'd0);
      chk("arst_rdata", cfg_rdata, tdata[0]);
      cfg_valid = 1'b0;
      tready    = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      run_req(1, 2, 1'b1);

      // Randomized traffic
      for (int k = 0; k < 24; k++) begin
         int  ridx;
         int  rdel;
         bit  rrw;
         for (int t = 0; t < NB; t++) tdata[t] = $urandom;
         ridx = $urandom_range(0, 3);
         rdel = $urandom_range(0, 12);
         rrw  = 1'($urandom_range(0, 1));
         run_req(ridx, rdel, rrw);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
